// File: rtl/bsg_dff_en_pipe_pkg.sv
// Shared helpers for the elastic enabled-DFF pipeline: count width and assertion text.
package bsg_dff_en_pipe_pkg;

  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  localparam string yumi_no_v_msg_c      = "bsg_dff_en_pipe: yumi_i asserted while v_o is low";
  localparam string count_mismatch_msg_c = "bsg_dff_en_pipe: count_o differs from number of valid stages";

endpackage

// File: rtl/bsg_dff_en_pipe_stage.sv
// One pipeline stage: valid bit plus data register. Data loads only when the incoming
// word is valid, so bubbles leave the data flops untouched.
module bsg_dff_en_pipe_stage
  import bsg_dff_en_pipe_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic               v_q, v_d;
  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (clear_i) begin
      v_d = 1'b0;
    end else if (en_i) begin
      v_d = v_i;
      if (v_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_en_pipe.sv
// Elastic valid/ready register pipeline with bubble collapsing and occupancy count.
// Optional synchronous flush input clear_i when BSG_DFF_EN_PIPE_CLEAR_EN is defined.
module bsg_dff_en_pipe
  import bsg_dff_en_pipe_pkg::*;
#(
  parameter  int width_p        = 32,
  parameter  int depth_p        = 2,
  localparam int count_width_lp = count_width(depth_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
`ifdef BSG_DFF_EN_PIPE_CLEAR_EN
  input  logic                      clear_i,
`endif
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic [count_width_lp-1:0] count_o
);

  if (depth_p < 1) begin : g_bad_depth
    $error("bsg_dff_en_pipe: depth_p must be >= 1");
  end

  logic [depth_p-1:0] valid_q;
  logic [depth_p-1:0] rdy;
  logic [depth_p-1:0] up_v;
  logic [width_p-1:0] up_data [depth_p];
  logic [width_p-1:0] data_q  [depth_p];
  logic               clear;

`ifdef BSG_DFF_EN_PIPE_CLEAR_EN
  assign clear = clear_i;
`else
  assign clear = 1'b0;
`endif

  // rdy[k] is the unrolled chain: stage k can move if any stage from k to the
  // output is empty, or the output is being consumed.
  for (genvar k = 0; k < depth_p; k++) begin : g_stage
    assign rdy[k] = yumi_i | ~(&valid_q[depth_p-1:k]);

    if (k == 0) begin : g_head
      assign up_v[k]    = v_i;
      assign up_data[k] = data_i;
    end else begin : g_body
      assign up_v[k]    = valid_q[k-1];
      assign up_data[k] = data_q[k-1];
    end

    bsg_dff_en_pipe_stage #(
      .width_p(width_p)
    ) u_stage (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .clear_i  (clear),
      .en_i     (rdy[k]),
      .v_i      (up_v[k]),
      .data_i   (up_data[k]),
      .v_o      (valid_q[k]),
      .data_o   (data_q[k])
    );
  end

  assign ready_o = rdy[0] & ~clear;
  assign v_o     = valid_q[depth_p-1];
  assign data_o  = data_q[depth_p-1];

  logic                      accept, consume;
  logic [count_width_lp-1:0] count_q, count_d;

  assign accept  = v_i & ready_o;
  assign consume = yumi_i & v_o;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (accept && !consume) begin
      count_d = count_q + count_width_lp'(1);
    end else if (consume && !accept) begin
      count_d = count_q - count_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count_o = count_q;

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("%s", yumi_no_v_msg_c);

  a_count_matches: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    count_q == count_width_lp'($countones(valid_q)))
    else $error("%s", count_mismatch_msg_c);

endmodule
